// File: rtl/seq_pkg.sv
// Shared types and constant tables for the repeated-number sequence controller.
package seq_pkg;

   localparam int unsigned CW = 4;
   localparam int unsigned NUM_POS = 10;

   localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_POS - 1);
   localparam logic [CW-1:0] HOME_CODE = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   // Element [0] is the rightmost entry.
   localparam logic [NUM_POS-1:0][CW-1:0] SEQ_MOD = {
      4'd1, 4'd0, 4'd13, 4'd3, 4'd14, 4'd7, 4'd5, 4'd2, 4'd4, 4'd6
   };
   localparam logic [NUM_POS-1:0][CW-1:0] SEQ_ORIG = {
      4'd0, 4'd0, 4'd13, 4'd3, 4'd14, 4'd4, 4'd2, 4'd2, 4'd4, 4'd6
   };

endpackage

// File: rtl/seq_rom.sv
// Stateless lookup: original value at the current position, and the position/code that follows it.
module seq_rom
   import seq_pkg::*;
(
   input  logic [CW-1:0] idx,
   output logic [CW-1:0] orig,
   output logic [CW-1:0] next_idx,
   output logic [CW-1:0] next_code,
   output logic          wrap
);

   // Any position outside 0..9 reads as 0 and recovers to position 0.
   always_comb begin
      orig     = '0;
      next_idx = '0;
      wrap     = 1'b0;
      if (idx <= LAST_IDX) begin
         orig = SEQ_ORIG[idx];
         if (idx == LAST_IDX) begin
            wrap = 1'b1;
         end else begin
            next_idx = idx + CW'(1);
         end
      end
      next_code = SEQ_MOD[next_idx];
   end

endmodule

// File: rtl/sequence_controller.sv
// Run-control sequencer: start/pause/step, prescaled advance, lap counting and finite run length.
module sequence_controller
   import seq_pkg::*;
#(
   parameter int unsigned DIV = 1,
   parameter int unsigned PW  = 8
) (
   input  logic          C,
   input  logic          R,
   input  logic          start,
   input  logic          pause,
   input  logic          step,
   input  logic [CW-1:0] laps,
   output logic [CW-1:0] Q,
   output logic [CW-1:0] D,
   output logic [CW-1:0] idx,
   output logic          running,
   output logic          lap_pulse,
   output logic          done
);

   localparam int unsigned LW = CW + 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [CW-1:0] LAP_MAX  = '1;

   state_t        state, state_nxt;
   logic [CW-1:0] q_r, q_nxt;
   logic [CW-1:0] idx_r, idx_nxt;
   logic [PW-1:0] pre, pre_nxt;
   logic [CW-1:0] lap_cnt, lap_cnt_nxt;
   logic [CW-1:0] lap_target, lap_target_nxt;
   logic          lap_pulse_r, lap_pulse_nxt;
   logic          advance;

   logic [CW-1:0] rom_next_idx;
   logic [CW-1:0] rom_next_code;
   logic          rom_wrap;

   seq_rom u_rom (
      .idx       (idx_r),
      .orig      (D),
      .next_idx  (rom_next_idx),
      .next_code (rom_next_code),
      .wrap      (rom_wrap)
   );

   // State and datapath registers.
   always_ff @(posedge C) begin
      if (R) begin
         state       <= ST_IDLE;
         q_r         <= HOME_CODE;
         idx_r       <= '0;
         pre         <= '0;
         lap_cnt     <= '0;
         lap_target  <= '0;
         lap_pulse_r <= 1'b0;
      end else begin
         state       <= state_nxt;
         q_r         <= q_nxt;
         idx_r       <= idx_nxt;
         pre         <= pre_nxt;
         lap_cnt     <= lap_cnt_nxt;
         lap_target  <= lap_target_nxt;
         lap_pulse_r <= lap_pulse_nxt;
      end
   end

   // Next state: start overrides everything; otherwise RUN ticks the prescaler and PAUSE takes steps.
   always_comb begin
      state_nxt      = state;
      q_nxt          = q_r;
      idx_nxt        = idx_r;
      pre_nxt        = pre;
      lap_cnt_nxt    = lap_cnt;
      lap_target_nxt = lap_target;
      lap_pulse_nxt  = 1'b0;
      advance        = 1'b0;

      if (start) begin
         state_nxt      = pause ? ST_PAUSE : ST_RUN;
         q_nxt          = HOME_CODE;
         idx_nxt        = '0;
         pre_nxt        = '0;
         lap_cnt_nxt    = '0;
         lap_target_nxt = laps;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (pause) begin
                  state_nxt = ST_PAUSE;
               end else if (pre == PRE_LAST) begin
                  pre_nxt = '0;
                  advance = 1'b1;
               end else begin
                  pre_nxt = pre + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (!pause) state_nxt = ST_RUN;
               if (step)   advance   = 1'b1;
            end
            default: ;
         endcase

         if (advance) begin
            idx_nxt = rom_next_idx;
            q_nxt   = rom_next_code;
            if (rom_wrap) begin
               lap_pulse_nxt = 1'b1;
               if (lap_cnt != LAP_MAX) lap_cnt_nxt = lap_cnt + CW'(1);
               if ((lap_target != '0) &&
                   ((LW'(lap_cnt) + LW'(1)) == LW'(lap_target))) begin
                  state_nxt = ST_DONE;
               end
            end
         end
      end
   end

   // Status decode from the state register.
   always_comb begin
      running = (state == ST_RUN);
      done    = (state == ST_DONE);
   end

   assign Q         = q_r;
   assign idx       = idx_r;
   assign lap_pulse = lap_pulse_r;

endmodule

// File: tb/tb_sequence_controller.sv
// Scoreboard bench for sequence_controller at DIV=1 and DIV=3.
module tb_sequence_controller;

   typedef struct packed {
      logic [3:0] q;
      logic [3:0] d;
      logic [3:0] idx;
      logic       lp;
      logic       run;
      logic       dn;
   } obs_t;

   logic       C = 1'b0;
   logic       R, start, pause, step;
   logic [3:0] laps;

   logic [3:0] q1, d1, idx1, q3, d3, idx3;
   logic       run1, lp1, dn1, run3, lp3, dn3;
   obs_t       o1, o3;

   logic [3:0] mq [10] = '{4'd6, 4'd4, 4'd2, 4'd5, 4'd7, 4'd14, 4'd3, 4'd13, 4'd0, 4'd1};
   logic [3:0] od [10] = '{4'd6, 4'd4, 4'd2, 4'd2, 4'd4, 4'd14, 4'd3, 4'd13, 4'd0, 4'd0};

   obs_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 C = ~C;

   sequence_controller #(.DIV(1), .PW(8)) dut1 (
      .C(C), .R(R), .start(start), .pause(pause), .step(step), .laps(laps),
      .Q(q1), .D(d1), .idx(idx1), .running(run1), .lap_pulse(lp1), .done(dn1)
   );

   sequence_controller #(.DIV(3), .PW(8)) dut3 (
      .C(C), .R(R), .start(start), .pause(pause), .step(step), .laps(laps),
      .Q(q3), .D(d3), .idx(idx3), .running(run3), .lap_pulse(lp3), .done(dn3)
   );

   assign o1 = {q1, d1, idx1, lp1, run1, dn1};
   assign o3 = {q3, d3, idx3, lp3, run3, dn3};

   function automatic obs_t mk(int pos, logic lp, logic run, logic dn);
      obs_t r;
      r.q   = mq[pos];
      r.d   = od[pos];
      r.idx = 4'(pos);
      r.lp  = lp;
      r.run = run;
      r.dn  = dn;
      return r;
   endfunction

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic test_reset();
      obs_t e;
      R = 1'b1; start = 1'b1; pause = 1'b0; step = 1'b0; laps = 4'd0;
      for (int n = 0; n < 3; n++) begin
         sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
         if (n == 2) begin R = 1'b0; start = 1'b0; end
         tick();
         e = sb.pop_front();
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL reset_div1[%0d]: got %p want %p", n, o1, e);
         end
         checks++;
         if (o3 !== e) begin
            errors++;
            $display("FAIL reset_div3[%0d]: got %p want %p", n, o3, e);
         end
      end
   endtask

   task automatic test_free_run();
      obs_t e;
      laps = 4'd0;
      for (int n = 0; n <= 10; n++) sb.push_back(mk(n % 10, n == 10, 1'b1, 1'b0));
      start = 1'b1;
      for (int n = 0; n <= 10; n++) begin
         tick();
         start = 1'b0;
         e = sb.pop_front();
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL free_run[%0d]: got %p want %p", n, o1, e);
         end
      end
   endtask

   task automatic test_lap_target();
      obs_t e;
      laps = 4'd2;
      for (int n = 0; n <= 30; n++)
         sb.push_back(mk((n <= 20) ? n % 10 : 0, (n == 10) || (n == 20), n < 20, n >= 20));
      // Restart into PAUSE, step once, then release.
      sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk(1, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk(1, 1'b0, 1'b1, 1'b0));
      sb.push_back(mk(2, 1'b0, 1'b1, 1'b0));
      start = 1'b1;
      for (int n = 0; n <= 34; n++) begin
         if (n >= 21 && n <= 30) begin
            step  = n[0];
            pause = n[1];
         end else if (n == 31) begin
            start = 1'b1; pause = 1'b1; step = 1'b0;
         end else if (n == 32) begin
            start = 1'b0; step = 1'b1;
         end else if (n == 33) begin
            step = 1'b0; pause = 1'b0;
         end
         tick();
         if (n == 0) start = 1'b0;
         e = sb.pop_front();
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL lap_target[%0d]: got %p want %p", n, o1, e);
         end
      end
   endtask

   task automatic test_pause_step();
      obs_t e;
      logic pz [16] = '{0, 0,0,0,0, 1,1,1,1,1,1, 0,0,1,0,0};
      logic sz [16] = '{0, 0,0,0,0, 0,0,1,0,1,1, 0,0,0,1,0};
      int   ps [16] = '{0, 1,2,3,4, 4,4,5,5,6,7, 7,8,8,9,0};
      logic rn [16] = '{1, 1,1,1,1, 0,0,0,0,0,0, 1,1,0,1,1};
      laps = 4'd0;
      for (int n = 0; n < 16; n++) sb.push_back(mk(ps[n], n == 15, rn[n], 1'b0));
      for (int n = 0; n < 16; n++) begin
         start = (n == 0);
         pause = pz[n];
         step  = sz[n];
         tick();
         e = sb.pop_front();
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL pause_step[%0d]: got %p want %p", n, o1, e);
         end
      end
      start = 1'b0; pause = 1'b0; step = 1'b0;
   endtask

   task automatic test_div3();
      obs_t e;
      int   ps [16] = '{0, 0,0,1,1,1,2,2,2, 2,2,2, 3,3,3,4};
      laps = 4'd0;
      for (int n = 0; n < 16; n++) sb.push_back(mk(ps[n], 1'b0, !(n == 9 || n == 10), 1'b0));
      for (int n = 0; n < 16; n++) begin
         start = (n == 0);
         pause = (n == 9 || n == 10);
         tick();
         e = sb.pop_front();
         checks++;
         if (o3 !== e) begin
            errors++;
            $display("FAIL div3[%0d]: got %p want %p", n, o3, e);
         end
      end
      start = 1'b0; pause = 1'b0;
   endtask

   task automatic test_reset_restart();
      obs_t e;
      laps = 4'd0;
      // Run to Q=13, reset, idle one clock.
      for (int n = 0; n <= 7; n++) sb.push_back(mk(n, 1'b0, 1'b1, 1'b0));
      sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
      sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
      // Restart, one full lap plus up to Q=0.
      for (int n = 0; n <= 18; n++) sb.push_back(mk(n % 10, n == 10, 1'b1, 1'b0));
      // Abort at Q=0 with laps=1: the fresh lap must complete after exactly 10 advances.
      for (int n = 0; n <= 10; n++) sb.push_back(mk(n % 10, n == 10, n < 10, n == 10));
      for (int n = 0; n < 40; n++) begin
         start = (n == 0) || (n == 10) || (n == 29);
         R     = (n == 8);
         if (n == 29) laps = 4'd1;
         tick();
         e = sb.pop_front();
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL reset_restart[%0d]: got %p want %p", n, o1, e);
         end
      end
      start = 1'b0; R = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_free_run();
      test_lap_target();
      test_pause_step();
      test_div3();
      test_reset_restart();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
